sisc_mem_arb: RTL and testbench
===============================

// Module: sisc_mem_arb
// PURPOSE
//  Arbitrates one single-port unified memory between the SISC fetch unit (IF) and
//  the load/store path (DM, LOD/STR). Latches the winner's request, drives the
//  memory for one cycle, waits the fixed read latency and returns data with a one-cycle ack.
//  Sits between the ctrl FSM's fetch/mem stages and the memory model.
// PARAMETERS
//  AW          16  address width
//  DW          32  data width
//  MEM_LAT     1   cycles from mem_en (read) to valid mem_rdata; legal 1..7
//  STARVE_MAX  4   consecutive DM grants allowed while if_req is pending; legal 1..15
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  if_req     in   1   fetch request, held high until if_ack
//  if_addr    in   AW  fetch address (read only)
//  dm_req     in   1   data request, held high until dm_ack
//  dm_we      in   1   1 = store (STR), 0 = load (LOD)
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  store data
//  if_ack     out  1   one-cycle pulse: fetch complete, rdata valid
//  dm_ack     out  1   one-cycle pulse: data access complete (rdata valid if load)
//  rdata      out  DW  registered read data; holds until next read capture
//  busy       out  1   high in any state other than IDLE
//  mem_en     out  1   memory access strobe, exactly one cycle per grant
//  mem_we     out  1   memory write enable, valid with mem_en
//  mem_addr   out  AW  memory address, valid with mem_en
//  mem_wdata  out  DW  memory write data, valid with mem_en
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset: state=IDLE; if_ack, dm_ack, busy, mem_en, mem_we = 0; mem_addr, mem_wdata,
//   rdata = 0; starve_cnt = 0; lat_cnt = 0. All outputs registered.
//  FSM: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
//   IDLE: req sampled only here. No req: stay. Else grant, latch addr/we/wdata/owner.
//   ACCESS (1 cycle): mem_en=1 with latched addr/we/wdata. Store -> RESP; load -> WAIT.
//   WAIT: MEM_LAT cycles; capture mem_rdata into rdata at end of last WAIT cycle.
//   RESP (1 cycle): owner's ack=1; other ack=0. Next state IDLE.
//  Latency, req first high in IDLE at cycle 0: load ack in cycle 2+MEM_LAT;
//   store ack in cycle 2. Back-to-back: next grant earliest in cycle after RESP.
//  Requester drops req at the edge ending its ack cycle; req still high in IDLE = new request.
//  Arbitration: both req in IDLE -> DM wins, unless if_req && starve_cnt==STARVE_MAX -> IF wins.
//   starve_cnt: +1 on each DM grant while if_req high (saturates at STARVE_MAX);
//   cleared on IF grant or when if_req low in IDLE.
//  Latched fields: addr/data changes on req lines after grant are ignored.
//  rdata unchanged by stores; IF and DM share rdata, qualified by their own ack.
//  Reset mid-operation: rst wins over every transition; in-flight access abandoned,
//   no ack issued, late mem_rdata ignored, starve_cnt cleared.
//  if_req and dm_req never acked in the same cycle; at most one access in flight.
// STRUCTURE
//  Package sisc_mem_pkg: arb state enum (IDLE, ACCESS, WAIT, RESP), owner encoding
//   (OWN_IF=0, OWN_DM=1), default AW/DW constants shared with memory model.
//  No sub-module: FSM, 3-bit lat_cnt and 4-bit starve_cnt fit in one module.
// TESTING
//  Single IF load, MEM_LAT=1, addr 0x0010, mem holds 0x8123_4567 -> mem_en cycle 1,
//   if_ack cycle 3, rdata=0x8123_4567, busy high cycles 1-3.
//  DM store addr 0x0200 data 0xDEAD_BEEF -> mem_en=mem_we=1 cycle 1, dm_ack cycle 2,
//   rdata unchanged; readback via IF returns 0xDEAD_BEEF.
//  IF and DM req together in cycle 0 -> DM granted first, IF acked after DM RESP;
//   never both acks high.
//  IF held high, DM re-requests continuously, STARVE_MAX=4 -> 4 DM grants then 1 IF
//   grant, starve_cnt back to 0, pattern repeats.
//  MEM_LAT=3, rst pulsed in the 2nd WAIT cycle -> next cycle IDLE, no ack, outputs 0;
//   later mem_rdata does not update rdata.
//  dm_addr changed 0x0300->0x0400 after grant -> mem_addr=0x0300 in ACCESS.

Source files
------------

// File: rtl/sisc_mem_arb_pkg.sv
// Shared types and constants for the SISC unified-memory arbiter.
//  - arb_state_e : arbiter FSM states (IDLE, ACCESS, WAIT, RESP)
//  - owner_e     : which requester holds the current grant
//  - DEF_AW/DEF_DW : default address/data widths, also used by the memory model
//  - sat_inc4    : 4-bit saturating increment used by the starvation counter
package sisc_mem_arb_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/sisc_mem_arb_if.sv
// Bus bundle between the two requesters (fetch IF, load/store DM), the arbiter
// and the single-port memory.
//  Requester side : if_req/if_addr, dm_req/dm_we/dm_addr/dm_wdata -> arbiter
//                   if_ack/dm_ack/rdata/busy                       <- arbiter
//  Memory side    : mem_en/mem_we/mem_addr/mem_wdata               -> memory
//                   mem_rdata                                      <- memory
// Handshake: a requester raises req with its fields and holds them until it sees
// its own one-cycle ack; it drops req at the clock edge ending the ack cycle.
// A req still high when the arbiter is back in IDLE is a new request. Fields may
// change after the grant without effect. rdata is shared and is only meaningful
// in the cycle the reader's own ack is high (loads only).
// Modports: slave = arbiter view, master = requesters + memory model view.
interface sisc_mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_ack;
  logic          dm_ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, dm_ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, dm_ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sisc_mem_arb.sv
// Arbiter for one single-port unified memory shared by SISC fetch (IF) and the
// load/store path (DM). A request is sampled only in IDLE, its fields latched,
// the memory strobed for exactly one cycle, the fixed read latency waited out,
// and a one-cycle ack returned to the owner. DM has priority unless fetch has
// been passed over STARVE_MAX times in a row.
// Ports:
//  clk              in   clock, all state on rising edge
//  rst              in   synchronous active-high reset
//  io_bus           slave modport of sisc_mem_arb_if (requesters + memory)
//  o_dbg_state      out  current FSM state
//  o_dbg_starve_cnt out  consecutive DM grants while fetch was waiting
//  o_dbg_lat_cnt    out  read-latency counter inside WAIT
// Parameters: AW, DW widths; MEM_LAT read latency 1..7; STARVE_MAX 1..15.
module sisc_mem_arb
  import sisc_mem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  sisc_mem_arb_if.slave       io_bus,
  output arb_state_e          o_dbg_state,
  output logic [3:0]          o_dbg_starve_cnt,
  output logic [2:0]          o_dbg_lat_cnt
);

  localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e    r_state;
  owner_e        r_owner;
  logic          r_we;
  logic [3:0]    r_starve_cnt;
  logic [2:0]    r_lat_cnt;
  logic          r_if_ack;
  logic          r_dm_ack;
  logic [DW-1:0] r_rdata;
  logic          r_busy;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  arb_state_e    w_state_nxt;
  logic          w_grant;
  logic          w_grant_dm;
  logic          w_capture;
  logic [3:0]    w_starve_nxt;
  logic [2:0]    w_lat_nxt;

  // Next-state, grant decision and counter updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_dm   = 1'b0;
    w_capture    = 1'b0;
    w_starve_nxt = r_starve_cnt;
    w_lat_nxt    = 3'd0;
    case (r_state)
      IDLE: begin
        if (io_bus.if_req || io_bus.dm_req) begin
          w_grant     = 1'b1;
          // DM wins a tie unless fetch has already been passed over STARVE_MAX times.
          w_grant_dm  = io_bus.dm_req &&
                        !(io_bus.if_req && (r_starve_cnt == STARVE_LIM));
          w_state_nxt = ACCESS;
        end
        // Counts only DM grants that overtook a waiting fetch; an IF grant or an
        // idle fetch line clears it.
        w_starve_nxt = (io_bus.if_req && w_grant_dm) ? sat_inc4(r_starve_cnt, STARVE_LIM)
                                                     : 4'd0;
      end
      ACCESS: begin
        w_state_nxt = r_we ? RESP : WAIT;
      end
      WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_lat_nxt = r_lat_cnt + 3'd1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs, all derived from the next state so every
  // output lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_IF;
      r_we         <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_lat_cnt    <= 3'd0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_rdata      <= '0;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_mem_en     <= w_grant;
      r_mem_we     <= w_grant && w_grant_dm && io_bus.dm_we;
      // The latched fields double as the memory address/data outputs.
      if (w_grant) begin
        r_owner     <= w_grant_dm ? OWN_DM : OWN_IF;
        r_we        <= w_grant_dm && io_bus.dm_we;
        r_mem_addr  <= w_grant_dm ? io_bus.dm_addr : io_bus.if_addr;
        r_mem_wdata <= w_grant_dm ? io_bus.dm_wdata : '0;
      end
      r_if_ack <= (w_state_nxt == RESP) && (r_owner == OWN_IF);
      r_dm_ack <= (w_state_nxt == RESP) && (r_owner == OWN_DM);
      if (w_capture) begin
        r_rdata <= io_bus.mem_rdata;
      end
    end
  end

  assign io_bus.if_ack    = r_if_ack;
  assign io_bus.dm_ack    = r_dm_ack;
  assign io_bus.rdata     = r_rdata;
  assign io_bus.busy      = r_busy;
  assign io_bus.mem_en    = r_mem_en;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;
  assign o_dbg_lat_cnt    = r_lat_cnt;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Bench for sisc_mem_arb: one instance with MEM_LAT=1 for the functional tests and
// one with MEM_LAT=3 for the long-latency and mid-access reset tests. Each has a
// small behavioural memory whose read data appears MEM_LAT cycles after mem_en.
module tb_sisc_mem_arb;
  import sisc_mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic [DW-1:0] GARB = 32'hA5A5_A5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1;
  logic rst3;

  sisc_mem_arb_if #(.AW(AW), .DW(DW)) b1 ();
  sisc_mem_arb_if #(.AW(AW), .DW(DW)) b3 ();

  arb_state_e st1, st3;
  logic [3:0] sc1, sc3;
  logic [2:0] lc1, lc3;

  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst1), .io_bus(b1),
    .o_dbg_state(st1), .o_dbg_starve_cnt(sc1), .o_dbg_lat_cnt(lc1)
  );

  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst3), .io_bus(b3),
    .o_dbg_state(st3), .o_dbg_starve_cnt(sc3), .o_dbg_lat_cnt(lc3)
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] mem1 [int];
  logic [DW-1:0] mem3 [int];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  function automatic logic [DW-1:0] rd1(input logic [AW-1:0] a);
    return mem1.exists(int'(a)) ? mem1[int'(a)] : '0;
  endfunction
  function automatic logic [DW-1:0] rd3(input logic [AW-1:0] a);
    return mem3.exists(int'(a)) ? mem3[int'(a)] : '0;
  endfunction

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) mem1[int'(b1.mem_addr)] = b1.mem_wdata;
    pipe1 <= (b1.mem_en && !b1.mem_we) ? rd1(b1.mem_addr) : GARB;
  end
  assign b1.mem_rdata = pipe1;

  always @(posedge clk) begin
    if (b3.mem_en && b3.mem_we) mem3[int'(b3.mem_addr)] = b3.mem_wdata;
    pipe3[0] <= (b3.mem_en && !b3.mem_we) ? rd3(b3.mem_addr) : GARB;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b3.mem_rdata = pipe3[2];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q [$];   // {owner is DM, expected rdata at ack}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every ack on the MEM_LAT=1 instance is matched against the queue in order.
  always @(posedge clk) begin
    #1;
    if (!rst1 && (b1.if_ack || b1.dm_ack)) begin
      check("ack_exclusive", {63'd0, b1.if_ack && b1.dm_ack}, 64'd0);
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 64'd1, 64'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("ack_owner_rdata", {31'd0, b1.dm_ack, b1.rdata}, {31'd0, e});
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    bit            dm;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs [6];

  // Drive one request on the MEM_LAT=1 instance starting in an IDLE cycle (cycle 0)
  // and check strobe, busy and ack latency. Returns in the following IDLE cycle.
  task automatic run_req(input vec_t v);
    int cyc;
    bit got;
    exp_q.push_back({v.dm, v.exp_rdata});
    check("idle_at_c0", 64'(st1), 64'(IDLE));
    if (v.dm) begin
      b1.dm_req = 1'b1; b1.dm_we = v.we; b1.dm_addr = v.addr; b1.dm_wdata = v.wdata;
    end else begin
      b1.if_req = 1'b1; b1.if_addr = v.addr;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("mem_en_c1", 64'(b1.mem_en), 64'd1);
        check("mem_addr_c1", 64'(b1.mem_addr), 64'(v.addr));
        check("mem_we_c1", 64'(b1.mem_we), 64'(v.we));
        if (v.we) check("mem_wdata_c1", 64'(b1.mem_wdata), 64'(v.wdata));
      end else begin
        check("mem_en_single", 64'(b1.mem_en), 64'd0);
      end
      check("busy_active", 64'(b1.busy), 64'd1);
      if (v.dm ? b1.dm_ack : b1.if_ack) begin
        got = 1'b1;
        check("ack_latency", 64'(cyc), 64'(v.exp_lat));
      end
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    b1.if_req = 1'b0;
    b1.dm_req = 1'b0;
    @(posedge clk); #1;
    check("busy_idle_after", 64'(b1.busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dm_at;
    int if_at;
    int acks;
    int cyc;
    bit got;
    vec_t rb;

    vecs[0] = '{dm: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 32'h0,         exp_rdata: 32'h8123_4567, exp_lat: 3};
    vecs[1] = '{dm: 1'b1, we: 1'b1, addr: 16'h0200, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h8123_4567, exp_lat: 2};
    vecs[2] = '{dm: 1'b0, we: 1'b0, addr: 16'h0200, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF, exp_lat: 3};
    vecs[3] = '{dm: 1'b1, we: 1'b0, addr: 16'h0010, wdata: 32'h0,         exp_rdata: 32'h8123_4567, exp_lat: 3};
    vecs[4] = '{dm: 1'b1, we: 1'b1, addr: 16'h0400, wdata: 32'h0BAD_F00D, exp_rdata: 32'h8123_4567, exp_lat: 2};
    vecs[5] = '{dm: 1'b1, we: 1'b0, addr: 16'h0400, wdata: 32'h0,         exp_rdata: 32'h0BAD_F00D, exp_lat: 3};

    mem1[32'h0010] = 32'h8123_4567;
    mem1[32'h0300] = 32'h3333_0300;
    mem1[32'h0400] = 32'h4444_0400;
    mem3[32'h0010] = 32'h8123_4567;
    mem3[32'h0020] = 32'h1111_2222;
    pipe1 = GARB;
    for (int i = 0; i < 3; i++) pipe3[i] = GARB;

    b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    b1.dm_addr = '0; b1.dm_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0;
    b3.dm_addr = '0; b3.dm_wdata = '0;

    // ---- reset state ----
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(st1), 64'(IDLE));
    check("rst_busy", 64'(b1.busy), 64'd0);
    check("rst_mem_en", 64'(b1.mem_en), 64'd0);
    check("rst_mem_we", 64'(b1.mem_we), 64'd0);
    check("rst_mem_addr", 64'(b1.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(b1.mem_wdata), 64'd0);
    check("rst_rdata", 64'(b1.rdata), 64'd0);
    check("rst_acks", {62'd0, b1.if_ack, b1.dm_ack}, 64'd0);
    check("rst_starve", 64'(sc1), 64'd0);
    rst1 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    // ---- table-driven single accesses ----
    for (int i = 0; i < 6; i++) run_req(vecs[i]);

    // ---- fields changed after grant are ignored ----
    exp_q.push_back({1'b1, 32'h0BAD_F00D});
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 16'h0300; b1.dm_wdata = 32'hCAFE_0300;
    @(posedge clk); #1;
    b1.dm_addr = 16'h0400; b1.dm_wdata = 32'h5555_5555;
    check("latch_mem_en", 64'(b1.mem_en), 64'd1);
    check("latch_mem_addr", 64'(b1.mem_addr), 64'h0300);
    check("latch_mem_wdata", 64'(b1.mem_wdata), 64'hCAFE_0300);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk); #1;
      if (b1.dm_ack) got = 1'b1;
    end
    if (!got) check("latch_ack_timeout", 64'd0, 64'd1);
    b1.dm_req = 1'b0;
    @(posedge clk); #1;
    rb = '{dm: 1'b0, we: 1'b0, addr: 16'h0300, wdata: 32'h0, exp_rdata: 32'hCAFE_0300, exp_lat: 3};
    run_req(rb);
    rb = '{dm: 1'b0, we: 1'b0, addr: 16'h0400, wdata: 32'h0, exp_rdata: 32'h0BAD_F00D, exp_lat: 3};
    run_req(rb);

    // ---- simultaneous requests: DM first, then IF ----
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    exp_q.push_back({1'b0, 32'h8123_4567});
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 16'h0200;
    b1.if_req = 1'b1; b1.if_addr = 16'h0010;
    dm_at = -1; if_at = -1;
    for (int c = 1; c <= 30 && (dm_at < 0 || if_at < 0); c++) begin
      @(posedge clk); #1;
      if (b1.dm_ack && dm_at < 0) begin dm_at = c; b1.dm_req = 1'b0; end
      if (b1.if_ack && if_at < 0) begin if_at = c; b1.if_req = 1'b0; end
    end
    check("both_dm_ack_cycle", 64'(dm_at), 64'd3);
    check("both_if_ack_cycle", 64'(if_at), 64'd7);
    b1.dm_req = 1'b0; b1.if_req = 1'b0;
    @(posedge clk); #1;

    // ---- starvation: 4 DM grants then 1 IF, repeated ----
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      else            exp_q.push_back({1'b1, 32'hCAFE_0300});
    end
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 16'h0300;
    b1.if_req = 1'b1; b1.if_addr = 16'h0200;
    acks = 0;
    for (int c = 0; c < 200 && acks < 10; c++) begin
      @(posedge clk); #1;
      if (b1.dm_ack) begin
        acks++;
        if (acks % 5 == 4) check("starve_saturated", 64'(sc1), 64'd4);
      end
      if (b1.if_ack) begin
        acks++;
        check("starve_cleared", 64'(sc1), 64'd0);
      end
    end
    check("starve_ack_count", 64'(acks), 64'd10);
    b1.dm_req = 1'b0; b1.if_req = 1'b0;
    @(posedge clk); #1;

    // ---- MEM_LAT=3: normal load latency ----
    b3.if_req = 1'b1; b3.if_addr = 16'h0010;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (b3.if_ack) got = 1'b1;
    end
    check("lat3_ack_cycle", 64'(cyc), 64'd5);
    check("lat3_rdata", 64'(b3.rdata), 64'h8123_4567);
    b3.if_req = 1'b0;
    @(posedge clk); #1;

    // ---- MEM_LAT=3: reset in the 2nd WAIT cycle ----
    b3.if_req = 1'b1; b3.if_addr = 16'h0020;
    repeat (3) begin @(posedge clk); #1; end
    check("rst3_in_wait", 64'(st3), 64'(WAIT));
    rst3 = 1'b1;
    b3.if_req = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    check("rst3_state_idle", 64'(st3), 64'(IDLE));
    check("rst3_busy", 64'(b3.busy), 64'd0);
    check("rst3_mem_en", 64'(b3.mem_en), 64'd0);
    check("rst3_mem_addr", 64'(b3.mem_addr), 64'd0);
    check("rst3_rdata", 64'(b3.rdata), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rst3_no_ack", {62'd0, b3.if_ack, b3.dm_ack}, 64'd0);
      check("rst3_rdata_hold", 64'(b3.rdata), 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
